bip_control_unit: RTL
=====================

Name: bip_control_unit

Overview:
- Parametrised instruction-sequencing control unit for the BIP datapath.
- Next generation of the free-running program counter block. Adds reset, stall (enable), instruction decode, jumps, a conditional branch, a halt state and a retired-instruction counter.
- Drives the program-memory address, plus the accumulator/ALU/data-RAM control strobes, in a single-cycle-per-instruction scheme.

Parameters:
- bits_address, 11: program and data address width; also the operand field width.
- bits_opcode, 5: opcode field width. Instruction width is bits_opcode+bits_address, with the opcode in the MSBs.
- reset_vector, 0: PC value loaded on reset.
- bits_count, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = execute the current instruction this cycle; 0 = stall.
- instruction  input  bits_opcode+bits_address  word from program memory at address_output. Combinational read, valid in the same cycle.
- acc_zero  input  1  accumulator == 0 flag from the datapath.
- address_output  output  bits_address  program counter (program-memory address).
- operand  output  bits_address  low bits_address bits of instruction, passed straight through.
- sel_a  output  2  accumulator input mux: 0 = data RAM, 1 = immediate operand, 2 = ALU result.
- sel_b  output  1  ALU B operand: 0 = data RAM, 1 = immediate.
- op_sub  output  1  ALU operation: 0 = add, 1 = subtract.
- wr_acc  output  1  accumulator write strobe.
- wr_ram  output  1  data-RAM write strobe.
- rd_ram  output  1  data-RAM read strobe.
- halted  output  1  1 while in the HALT state.
- instr_count  output  bits_count  retired-instruction counter.

Behaviour:
- States: RUN and HALT.
  - reset (sampled at a clock edge) forces RUN, address_output = reset_vector, instr_count = 0 and halted = 0.
  - Reset has priority over every other condition, including a reset asserted mid-stall or while in HALT.
- Execute condition: exec = RUN & enable & !reset.
- Strobes are combinational from instruction and are gated by exec. With exec = 0, wr_acc, wr_ram and rd_ram are all 0; sel_a, sel_b and op_sub are don't-care but must be held at 0.
- Decode (opcode value: strobes set):
  - 00000 HLT: no strobes.
  - 00001 STO: wr_ram.
  - 00010 LD: rd_ram, wr_acc, sel_a = 0.
  - 00011 LDI: wr_acc, sel_a = 1.
  - 00100 ADD: rd_ram, wr_acc, sel_a = 2, sel_b = 0, op_sub = 0.
  - 00101 ADDI: wr_acc, sel_a = 2, sel_b = 1, op_sub = 0.
  - 00110 SUB: as ADD but op_sub = 1.
  - 00111 SUBI: as ADDI but op_sub = 1.
  - 01000 JMP: no strobes.
  - 01001 BNZ: no strobes.
  - Any other opcode: NOP, no strobes.
- PC update on a clock edge when exec = 1:
  - HLT: PC holds; next state is HALT.
  - JMP: PC <= operand.
  - BNZ: PC <= operand if acc_zero = 0, else PC + 1.
  - All others: PC <= PC + 1, wrapping modulo 2^bits_address (all ones -> 0).
- When exec = 0 (stall or HALT), PC, state and instr_count hold.
- HALT is exited only by reset.
- instr_count increments by 1 on every exec = 1 edge, including the HLT instruction itself. It saturates at all ones and never wraps.
- Latency: strobes have zero-cycle latency relative to instruction; the PC changes one edge after exec.
- A branch whose target equals its own address loops legally; the counter keeps counting until it saturates.

Test Plan:
- Reset and sequence: assert reset for 2 cycles, then run LDI 5; ADDI 3; STO 7; HLT.
  - After reset: address_output = 0, instr_count = 0.
  - PC steps 0, 1, 2, 3.
  - STO cycle: wr_ram = 1, operand = 7.
  - After HLT: halted = 1, PC stays 3, instr_count = 4.
- Stall: with enable = 0 for 3 cycles mid-program, PC, instr_count and all strobes hold with no strobe asserted. On re-enable, execution resumes at the same address.
- Branch: put BNZ 10 at address 4.
  - acc_zero = 0 -> PC becomes 10.
  - acc_zero = 1 -> PC becomes 5.
  - JMP 0x7FF -> PC = 2047; the next sequential instruction wraps PC to 0.
- Reset priority: assert reset while halted, and separately on a cycle where JMP 9 is presented. Both give PC = 0, halted = 0, instr_count = 0, and no strobes in that cycle.
- Saturation: with bits_count = 4, execute 20 NOPs (opcode 11111). instr_count reaches 15 and stays there; no strobes during any NOP.
- Decode sweep: present every opcode 0 to 31 with exec = 1. Strobes must match the decode list, and undefined opcodes must give all strobes 0 and PC + 1.

Source files
------------

// File: rtl/bip_control_unit.sv
// Instruction-sequencing control unit for the BIP datapath: program counter, decode of the
// accumulator/ALU/data-RAM strobes, jumps, a conditional branch, halt and a retired counter.
module bip_control_unit #(
  parameter int unsigned bits_address = 11,
  parameter int unsigned bits_opcode  = 5,
  parameter int unsigned reset_vector = 0,
  parameter int unsigned bits_count   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [bits_opcode+bits_address-1:0] instruction,
  input  logic                              acc_zero,
  output logic [bits_address-1:0]           address_output,
  output logic [bits_address-1:0]           operand,
  output logic [1:0]                        sel_a,
  output logic                              sel_b,
  output logic                              op_sub,
  output logic                              wr_acc,
  output logic                              wr_ram,
  output logic                              rd_ram,
  output logic                              halted,
  output logic [bits_count-1:0]             instr_count
);

  localparam int unsigned InstrWidth = bits_opcode + bits_address;

  localparam logic [bits_opcode-1:0] OpHlt  = bits_opcode'(0);
  localparam logic [bits_opcode-1:0] OpSto  = bits_opcode'(1);
  localparam logic [bits_opcode-1:0] OpLd   = bits_opcode'(2);
  localparam logic [bits_opcode-1:0] OpLdi  = bits_opcode'(3);
  localparam logic [bits_opcode-1:0] OpAdd  = bits_opcode'(4);
  localparam logic [bits_opcode-1:0] OpAddi = bits_opcode'(5);
  localparam logic [bits_opcode-1:0] OpSub  = bits_opcode'(6);
  localparam logic [bits_opcode-1:0] OpSubi = bits_opcode'(7);
  localparam logic [bits_opcode-1:0] OpJmp  = bits_opcode'(8);
  localparam logic [bits_opcode-1:0] OpBnz  = bits_opcode'(9);

  localparam logic [1:0] SelAccRam = 2'd0;
  localparam logic [1:0] SelAccImm = 2'd1;
  localparam logic [1:0] SelAccAlu = 2'd2;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e                  state_q, state_d;
  logic [bits_address-1:0] pc_q, pc_d;
  logic [bits_count-1:0]   count_q, count_d;

  logic [bits_opcode-1:0]  opcode;
  logic [bits_address-1:0] pc_inc;
  logic                    exec;

  assign opcode  = instruction[InstrWidth-1 -: bits_opcode];
  assign operand = instruction[bits_address-1:0];
  assign pc_inc  = pc_q + bits_address'(1);

  // Reset wins even combinationally, so no strobe leaks out during a reset cycle.
  assign exec = (state_q == StRun) && enable && !reset;

  // Strobe decode; everything stays at 0 when not executing.
  always_comb begin
    sel_a  = SelAccRam;
    sel_b  = 1'b0;
    op_sub = 1'b0;
    wr_acc = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    if (exec) begin
      case (opcode)
        OpSto: wr_ram = 1'b1;
        OpLd: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = SelAccRam;
        end
        OpLdi: begin
          wr_acc = 1'b1;
          sel_a  = SelAccImm;
        end
        OpAdd, OpSub: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = SelAccAlu;
          op_sub = (opcode == OpSub);
        end
        OpAddi, OpSubi: begin
          wr_acc = 1'b1;
          sel_a  = SelAccAlu;
          sel_b  = 1'b1;
          op_sub = (opcode == OpSubi);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (exec) begin
      // HLT retires too, so the counter steps on every executed edge.
      count_d = (&count_q) ? count_q : count_q + bits_count'(1);
      case (opcode)
        OpHlt:   state_d = StHalt;
        OpJmp:   pc_d    = operand;
        OpBnz:   pc_d    = acc_zero ? pc_inc : operand;
        default: pc_d    = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= bits_address'(reset_vector);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign address_output = pc_q;
  assign instr_count    = count_q;
  assign halted         = (state_q == StHalt);

endmodule
